// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine with req/ready memory handshake, stall and MEM->WB register
module mem_access_unit #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             regwrite_mem,
    input  logic             memtoreg_mem,
    input  logic             memwrite_mem,
    input  logic [WIDTH-1:0] aluout_mem,
    input  logic [WIDTH-1:0] writedata_mem,
    input  logic [4:0]       regaddr_mem,
    output logic             stall_mem,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic             dmem_ready,
    input  logic [WIDTH-1:0] dmem_rdata,
    output logic             regwrite_wb,
    output logic             memtoreg_wb,
    output logic [WIDTH-1:0] aluout_wb,
    output logic [WIDTH-1:0] readdata_wb,
    output logic [4:0]       regaddr_wb,
    output logic             err_misalign,
    output logic             err_timeout
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic memop, misal, start, done, tmo, pass;
    assign memop = memtoreg_mem | memwrite_mem;
    assign misal = memop & (aluout_mem[1:0] != 2'b00);
    assign start = (state == IDLE) & memop & !misal;
    assign done  = (state == WAIT) & dmem_ready;
    assign tmo   = (state == WAIT) & !dmem_ready & (cnt == CW'(TIMEOUT - 1));
    assign pass  = ((state == IDLE) & !memop) | done;
    always_comb begin
        state_n   = state;
        stall_mem = 1'b0;
        if (state == IDLE) begin
            stall_mem = start;
            state_n   = start ? WAIT : IDLE;
        end else begin
            stall_mem = !dmem_ready & !tmo;
            state_n   = (done | tmo) ? IDLE : WAIT;
        end
        stall_mem = stall_mem & !rst;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            regwrite_wb  <= 1'b0;
            memtoreg_wb  <= 1'b0;
            aluout_wb    <= '0;
            readdata_wb  <= '0;
            regaddr_wb   <= '0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            state        <= state_n;
            err_misalign <= (state == IDLE) & misal;
            err_timeout  <= tmo;
            if (start) begin
                dmem_req   <= 1'b1;
                dmem_we    <= memwrite_mem;
                dmem_addr  <= aluout_mem;
                dmem_wdata <= writedata_mem;
                cnt        <= '0;
            end else if (done | tmo) begin
                dmem_req <= 1'b0;
            end else if (state == WAIT) begin
                cnt <= cnt + 1'b1;
            end
            // anything not passing through is written as an all-zero bubble
            regwrite_wb <= pass & regwrite_mem;
            memtoreg_wb <= pass & memtoreg_mem;
            aluout_wb   <= pass ? aluout_mem : '0;
            regaddr_wb  <= pass ? regaddr_mem : 5'd0;
            readdata_wb <= done ? dmem_rdata : '0;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed plus random load/store/ALU traffic against a transaction-level model
module tb_mem_access_unit;
    localparam int TO = 4;
    logic        clk = 1'b0, rst = 1'b0;
    logic        regwrite_mem = 1'b0, memtoreg_mem = 1'b0, memwrite_mem = 1'b0;
    logic [31:0] aluout_mem = '0, writedata_mem = '0;
    logic [4:0]  regaddr_mem = '0;
    logic        stall_mem, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        regwrite_wb, memtoreg_wb;
    logic [31:0] aluout_wb, readdata_wb;
    logic [4:0]  regaddr_wb;
    logic        err_misalign, err_timeout;
    int checks = 0, errors = 0;

    mem_access_unit #(.WIDTH(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .regwrite_mem(regwrite_mem), .memtoreg_mem(memtoreg_mem), .memwrite_mem(memwrite_mem),
        .aluout_mem(aluout_mem), .writedata_mem(writedata_mem), .regaddr_mem(regaddr_mem),
        .stall_mem(stall_mem), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .regwrite_wb(regwrite_wb), .memtoreg_wb(memtoreg_wb),
        .aluout_wb(aluout_wb), .readdata_wb(readdata_wb), .regaddr_wb(regaddr_wb),
        .err_misalign(err_misalign), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req"}, 32'(dmem_req), 0);
        chk({tag, "_stall"}, 32'(stall_mem), 0);
        chk({tag, "_rw"}, 32'(regwrite_wb), 0);
        chk({tag, "_mtr"}, 32'(memtoreg_wb), 0);
        chk({tag, "_alu"}, aluout_wb, 0);
        chk({tag, "_rd"}, readdata_wb, 0);
        chk({tag, "_ra"}, 32'(regaddr_wb), 0);
        chk({tag, "_errs"}, {30'd0, err_misalign, err_timeout}, 0);
    endtask

    // n = WAIT cycles the memory lets pass before raising ready; n >= TO never answers
    task automatic do_op(input logic rw, input logic mtr, input logic mw,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] ra,
                         input int n, input logic [31:0] rdat);
        int stalls = 0, reqs = 0, k = 0, exp_cyc;
        logic done = 1'b0;
        logic memop, mis, tmo, commit;
        regwrite_mem = rw; memtoreg_mem = mtr; memwrite_mem = mw;
        aluout_mem = alu; writedata_mem = wd; regaddr_mem = ra;
        memop  = mtr | mw;
        mis    = memop && (alu[1:0] != 2'b00);
        tmo    = memop && !mis && (n >= TO);
        commit = !memop || (!mis && !tmo);
        exp_cyc = (!memop || mis) ? 0 : (tmo ? TO : n + 1);
        while (!done && k < 64) begin
            @(negedge clk);
            dmem_ready = dmem_req ? (reqs == n) : 1'($urandom_range(0, 1));
            dmem_rdata = (dmem_req && reqs == n) ? rdat : $urandom;
            #1;
            if (dmem_req) begin
                reqs++;
                chk("req_we", 32'(dmem_we), 32'(mw));
                chk("req_addr", dmem_addr, alu);
                if (mw) chk("req_wdata", dmem_wdata, wd);
            end
            if (k > 0) chk("wait_bubble", {30'd0, regwrite_wb, memtoreg_wb}, 0);
            if (stall_mem) stalls++; else done = 1'b1;
            k++;
        end
        chk("op_done", 32'(done), 1);
        @(posedge clk);
        #1;
        dmem_ready = 1'b0;
        chk("stall_cycles", stalls, exp_cyc);
        chk("req_cycles", reqs, exp_cyc);
        chk("req_dropped", 32'(dmem_req), 0);
        chk("err_misalign", 32'(err_misalign), 32'(mis));
        chk("err_timeout", 32'(err_timeout), 32'(tmo));
        chk("wb_regwrite", 32'(regwrite_wb), 32'(commit & rw));
        chk("wb_memtoreg", 32'(memtoreg_wb), 32'(commit & mtr));
        if (commit) begin
            chk("wb_aluout", aluout_wb, alu);
            chk("wb_regaddr", 32'(regaddr_wb), 32'(ra));
            chk("wb_readdata", readdata_wb, memop ? rdat : 32'd0);
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 chk_zero("reset");
        #10 rst = 1'b0;
        @(posedge clk);
        #1;
        do_op(1, 0, 0, 32'h0000_1234, 32'h0, 5'd5, 0, 32'h0);
        do_op(1, 1, 0, 32'h0000_0100, 32'h0, 5'd8, 2, 32'hDEAD_BEEF);
        do_op(0, 0, 1, 32'h0000_0200, 32'hCAFE_F00D, 5'd0, 0, 32'h0);
        do_op(1, 1, 0, 32'h0000_0102, 32'h0, 5'd9, 0, 32'h0);
        do_op(1, 1, 0, 32'h0000_0300, 32'h0, 5'd10, TO + 3, 32'h0);
        do_op(1, 0, 0, 32'h0000_0ABC, 32'h0, 5'd11, 0, 32'h0);
        do_op(1, 1, 0, 32'h0000_0400, 32'h0, 5'd12, TO - 1, 32'h1357_9BDF);
        for (int i = 0; i < 40; i++) begin
            int kind = $urandom_range(0, 3);
            logic [31:0] a = $urandom;
            logic [4:0] r = 5'($urandom);
            int n = $urandom_range(0, TO + 1);
            case (kind)
                0: do_op(1, 0, 0, a, $urandom, r, n, $urandom);
                1: do_op(1, 1, 0, {a[31:2], 2'b00}, $urandom, r, n, $urandom);
                2: do_op(0, 0, 1, {a[31:2], 2'b00}, $urandom, r, n, $urandom);
                default: do_op(1, $urandom_range(0, 1) == 1, 1'b0, {a[31:2], 2'($urandom_range(1, 3))}, $urandom, r, n, $urandom);
            endcase
            if (kind == 3 && !memtoreg_mem) do_op(0, 0, 1, {a[31:2], 2'b01}, $urandom, r, n, $urandom);
        end
        regwrite_mem = 1'b1; memtoreg_mem = 1'b1; memwrite_mem = 1'b0;
        aluout_mem = 32'h0000_0500; regaddr_mem = 5'd3;
        @(negedge clk);
        @(negedge clk);
        #1 chk("pre_reset_req", 32'(dmem_req), 1);
        rst = 1'b1;
        regwrite_mem = 1'b0; memtoreg_mem = 1'b0; aluout_mem = '0; regaddr_mem = '0;
        #1 chk_zero("mid_wait_reset");
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        do_op(1, 0, 0, 32'h0000_0777, 32'h0, 5'd7, 0, 32'h0);
        do_op(1, 0, 0, 32'h0000_0888, 32'h0, 5'd8, 0, 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage engine of the pipelined MIPS core. It consumes the EXE→MEM pipeline register outputs and performs loads and stores over a req/ready data-memory handshake. It stalls the upstream pipeline while an access is outstanding and registers the MEM→WB stage (control, ALU result, load data, destination register). Non-memory instructions pass through in one cycle.

## Interface
- WIDTH, 32, datapath and address width (matches `WIDTH)
- TIMEOUT, 16, maximum WAIT cycles before an access is aborted (≥1)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- regwrite_mem, memtoreg_mem, memwrite_mem  in  1 each  control from EXE→MEM register
- aluout_mem  in  WIDTH  ALU result / byte address
- writedata_mem  in  WIDTH  store data
- regaddr_mem  in  5  destination register
- stall_mem  out  1  combinational; high freezes PC, IF/ID, ID/EXE, EXE→MEM registers
- dmem_req  out  1  memory request (registered)
- dmem_we  out  1  1 = store, 0 = load (registered)
- dmem_addr, dmem_wdata  out  WIDTH  request address / store data (registered)
- dmem_ready  in  1  memory completes the request in this cycle
- dmem_rdata  in  WIDTH  load data, valid when dmem_ready=1
- regwrite_wb, memtoreg_wb  out  1  registered MEM→WB control
- aluout_wb, readdata_wb  out  WIDTH  registered ALU result / load data
- regaddr_wb  out  5  registered destination register
- err_misalign, err_timeout  out  1  one-cycle registered error pulses

## Operation
- memop = memtoreg_mem | memwrite_mem; misal = memop & (aluout_mem[1:0] != 0).
- FSM states: IDLE, WAIT.
- IDLE, !memop: next edge loads the WB register from the *_mem inputs (readdata_wb ← 0). stall_mem = 0.
- IDLE, misal: no request is issued. The next edge writes a bubble into WB (regwrite_wb=0, memtoreg_wb=0) and pulses err_misalign. stall_mem = 0, and the instruction is dropped.
- IDLE, memop & !misal: stall_mem = 1. Next edge: dmem_req←1, dmem_we←memwrite_mem, dmem_addr←aluout_mem, dmem_wdata←writedata_mem, wait counter←0, WB←bubble, state→WAIT.
- WAIT, !dmem_ready: stall_mem = 1, counter increments, WB←bubble.
  - If counter == TIMEOUT-1 at that edge: dmem_req←0, err_timeout pulses, WB←bubble, state→IDLE. The instruction is dropped and stall_mem is 0 during that final cycle.
- WAIT, dmem_ready: stall_mem = 0. Next edge: dmem_req←0, WB←{regwrite_mem, memtoreg_mem, aluout_mem, dmem_rdata, regaddr_mem}, state→IDLE.
  - For a store, readdata_wb ← dmem_rdata but is ignored (memtoreg=0).
- While dmem_req = 1, dmem_we, dmem_addr and dmem_wdata stay stable.
- A request is only dropped on dmem_ready or timeout, never otherwise.
- Upstream holds the *_mem inputs stable while stall_mem = 1; the unit relies on this in WAIT.

## Timing
- Reset (asynchronous): state=IDLE, counter=0, and every registered output = 0 (dmem_req, dmem_we, dmem_addr, dmem_wdata, all *_wb, err_*). With all inputs 0, stall_mem = 0.
- Reset during WAIT aborts the request immediately. No error pulse is produced.
- Non-memory op latency: 1 cycle (EXE→MEM to WB).
- Load/store with ready after N cycles in WAIT:
  - Latency is N+2 cycles.
  - stall_mem is high for N+1 cycles.
  - Ready on the first WAIT cycle gives a 2-cycle latency and 1 stall cycle.
- dmem_ready while in IDLE is ignored.
- Error pulses are high exactly one cycle and coincide with the bubble in WB.

## Test plan
- Reset, then an ALU op (regwrite=1, aluout=0x0000_1234, regaddr=5) → next cycle regwrite_wb=1, aluout_wb=0x1234, regaddr_wb=5, stall_mem never high, dmem_req stays 0.
- Load at aluout=0x100, memory ready on the 3rd WAIT cycle with rdata=0xDEADBEEF:
  - stall_mem high for 3 cycles, dmem_req high for 3 cycles at addr 0x100 with we=0.
  - WB then shows memtoreg_wb=1, readdata_wb=0xDEADBEEF; bubbles precede it.
- Store at 0x200 with data 0xCAFEF00D, ready on the first WAIT cycle → dmem_we=1, dmem_wdata=0xCAFEF00D, 1 stall cycle, regwrite_wb=0.
- Load at 0x102 → no dmem_req, err_misalign one-cycle pulse, WB bubble, stall_mem=0.
- Load with dmem_ready held low, TIMEOUT=4 → dmem_req high for 4 cycles then drops, err_timeout pulses once, pipeline resumes.
- Assert rst mid-WAIT → dmem_req, stall_mem and all WB outputs go to 0 immediately. After release, a back-to-back ALU op completes normally.
